imem_loader: RTL and testbench

Instruction-memory loader and storage for the five-stage MIPS core. It receives a program as a byte stream over a valid/ready handshake and packs it big-endian into 32-bit words. It verifies an XOR checksum and holds the core in reset until a good image is loaded. It also provides the registered instruction read port that the fetch stage reads from, so this block is the writer to fetch's reader.

---
 rtl/imem_loader.sv | 179 +++++++++++++++++
 tb/tb_imem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, checksummed byte stream and packs it
// big-endian into a 32-bit instruction memory. It holds the core in reset until
// a good image has loaded and provides the registered fetch read port.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             load request pulse (honoured in IDLE / DONE only)
//   i_rx_data/valid     image byte stream in
//   o_rx_ready          loader accepts a byte this cycle
//   i_fetch_pc          fetch-stage byte address
//   o_fetch_ir          instruction at i_fetch_pc[AW+1:2], one-cycle latency
//   o_cpu_reset         core reset hold
//   o_load_done         load sequence finished (pass or fail)
//   o_load_err          last load failed (bad length or checksum)
//   o_words_loaded      words written by the current / last load
module imem_loader #(
    parameter int unsigned WORDS = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    output logic          o_rx_ready,
    input  logic [31:0]   i_fetch_pc,
    output logic [31:0]   o_fetch_ir,
    output logic          o_cpu_reset,
    output logic          o_load_done,
    output logic          o_load_err,
    output logic [AW:0]   o_words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_rx_ready;
    logic          r_cpu_reset;
    logic          r_load_done;
    logic          r_load_err;
    logic [AW:0]   r_words;
    logic [AW-1:0] r_len;
    logic [AW-1:0] r_addr;
    logic [1:0]    r_bcnt;
    logic [7:0]    r_xor;
    logic [23:0]   r_asm;
    logic [31:0]   r_fetch_ir;
    logic [31:0]   r_mem [WORDS];

    logic          w_accept;
    logic          w_len_bad;
    logic          w_csum_bad;
    logic          w_word_end;
    logic          w_we;
    logic [31:0]   w_wdata;
    logic          w_unused_pc;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_LEN;
            S_LEN:  if (w_accept) w_state_nxt = w_len_bad ? S_DONE : S_DATA;
            S_DATA: if (w_accept && w_word_end && (r_addr == r_len)) w_state_nxt = S_CSUM;
            S_CSUM: if (w_accept) w_state_nxt = S_DONE;
            S_DONE: if (i_start) w_state_nxt = S_LEN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Per-cycle control decode
    always_comb begin
        w_accept   = i_rx_valid && r_rx_ready;
        w_len_bad  = (32'(i_rx_data) >= WORDS);
        w_csum_bad = (i_rx_data != r_xor);
        w_word_end = (r_bcnt == 2'd3);
        w_wdata    = {r_asm, i_rx_data};
        w_we       = 1'b0;
        if ((r_state == S_DATA) && w_accept && w_word_end && !i_reset) w_we = 1'b1;
    end

    // Loader datapath and registered status outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_words     <= '0;
            r_len       <= '0;
            r_addr      <= '0;
            r_bcnt      <= '0;
            r_xor       <= '0;
            r_asm       <= '0;
        end else begin
            // ready tracks the state being entered so streaming has no bubbles
            r_rx_ready <= (w_state_nxt == S_LEN) || (w_state_nxt == S_DATA) ||
                          (w_state_nxt == S_CSUM);
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_load_done <= 1'b0;
                        r_load_err  <= 1'b0;
                        r_cpu_reset <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        if (w_len_bad) begin
                            r_load_err  <= 1'b1;
                            r_load_done <= 1'b1;
                        end else begin
                            r_len   <= AW'(i_rx_data);
                            r_bcnt  <= '0;
                            r_addr  <= '0;
                            r_xor   <= '0;
                            r_words <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_xor  <= r_xor ^ i_rx_data;
                        r_asm  <= {r_asm[15:0], i_rx_data};
                        r_bcnt <= r_bcnt + 2'd1;
                        if (w_word_end) begin
                            r_addr  <= r_addr + AW'(1);
                            r_words <= r_words + (AW+1)'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        r_load_err  <= w_csum_bad;
                        r_load_done <= 1'b1;
                        r_cpu_reset <= w_csum_bad;
                    end
                end
                default: ;
            endcase
        end
    end

    // Instruction memory write port (no reset on storage)
    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[r_addr] <= w_wdata;
    end

    // Registered fetch read; same-word write returns old contents
    always_ff @(posedge i_clk) begin
        if (i_reset) r_fetch_ir <= '0;
        else         r_fetch_ir <= r_mem[i_fetch_pc[AW+1:2]];
    end

    // Upper PC bits and byte offset are intentionally ignored
    assign w_unused_pc = ^{i_fetch_pc[31:AW+2], i_fetch_pc[1:0]};

    assign o_rx_ready     = r_rx_ready;
    assign o_fetch_ir     = r_fetch_ir;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_load_done    = r_load_done;
    assign o_load_err     = r_load_err;
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized image loads checked against a
// word-level memory model; expected load results and fetch words are queued
// by the stimulus and consumed by a monitor.
module tb_imem_loader;
    localparam int unsigned WORDS = 128;
    localparam int unsigned AW    = 7;

    logic          clk = 1'b0;
    logic          reset, start, rx_valid, rx_ready;
    logic [7:0]    rx_data;
    logic [31:0]   fetch_pc, fetch_ir;
    logic          cpu_reset, load_done, load_err;
    logic [AW:0]   words_loaded;

    always #5 clk = ~clk;

    imem_loader #(.WORDS(WORDS), .AW(AW)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start),
        .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
        .i_fetch_pc(fetch_pc), .o_fetch_ir(fetch_ir),
        .o_cpu_reset(cpu_reset), .o_load_done(load_done), .o_load_err(load_err),
        .o_words_loaded(words_loaded)
    );

    typedef struct {
        logic err;
        int   wl;
        logic chk_wl;
    } exp_load_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          stall_cnt = 0;
    logic [31:0] mdl_mem [WORDS];
    logic        mdl_vld [WORDS];
    logic [31:0] img     [WORDS];
    exp_load_t   lq[$];
    logic [31:0] fq[$];
    logic        fetch_vld = 1'b0;
    logic        fetch_chk = 1'b0;
    logic        done_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: fetch results one cycle after a request; load results on load_done rise
    always @(posedge clk) fetch_chk <= fetch_vld;

    always @(negedge clk) begin
        exp_load_t   el;
        logic [31:0] ef;
        if (fetch_chk) begin
            if (fq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL fetch_queue: fetch presented with nothing expected");
            end else begin
                ef = fq.pop_front();
                chk("fetch_ir", fetch_ir, ef);
            end
        end
        if (load_done === 1'b1 && done_prev !== 1'b1) begin
            if (lq.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL load_queue: load_done with nothing expected");
            end else begin
                el = lq.pop_front();
                chk("load_err", 32'(load_err), 32'(el.err));
                chk("cpu_reset", 32'(cpu_reset), 32'(el.err));
                chk("rx_ready_in_done", 32'(rx_ready), 32'd0);
                if (el.chk_wl) chk("words_loaded", 32'(words_loaded), 32'(el.wl));
            end
        end
        done_prev = load_done;
    end

    task automatic send_byte(input logic [7:0] b, input bit gap, input bit rstart,
                             input bit do_f, input logic [31:0] fpc, input logic [31:0] fexp);
        int waitc;
        if (gap) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        waitc = 0;
        while (rx_ready !== 1'b1 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
            stall_cnt++;
        end
        if (waitc >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL rx_ready_timeout: got rx_ready=%b expected 1", rx_ready);
        end
        if (rstart && $urandom_range(0, 2) == 0) start = 1'b1;
        if (do_f) begin
            fetch_pc  = fpc;
            fetch_vld = 1'b1;
            fq.push_back(fexp);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        fetch_vld = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int waitc = 0;
        while (load_done !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (load_done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL load_done_timeout: got %b expected 1", load_done);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    // Load img[0..L] (or reject L >= WORDS); collide = word whose write edge is also read
    task automatic do_load(input int L, input bit ok, input bit gap, input bit rstart,
                           input int collide);
        exp_load_t  el;
        logic [7:0] x;
        logic [7:0] b;
        pulse_start();
        if (L >= int'(WORDS)) begin
            el.err = 1'b1; el.wl = 0; el.chk_wl = 1'b0;
            lq.push_back(el);
            send_byte(8'(L), gap, rstart, 1'b0, 32'd0, 32'd0);
            rx_valid = 1'b0;
        end else begin
            el.err = !ok; el.wl = L + 1; el.chk_wl = 1'b1;
            lq.push_back(el);
            send_byte(8'(L), gap, rstart, 1'b0, 32'd0, 32'd0);
            x = 8'h00;
            for (int i = 0; i <= L; i++) begin
                for (int j = 0; j < 4; j++) begin
                    b = img[i][(31 - 8*j) -: 8];
                    x = x ^ b;
                    send_byte(b, gap, rstart, (i == collide) && (j == 3),
                              32'(i * 4), mdl_mem[i]);
                end
                mdl_mem[i] = img[i];
                mdl_vld[i] = 1'b1;
            end
            send_byte(ok ? x : (x ^ 8'h01), gap, rstart, 1'b0, 32'd0, 32'd0);
            rx_valid = 1'b0;
        end
        wait_done();
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        int idx;
        idx = int'(pc[AW+1:2]);
        if (mdl_vld[idx]) begin
            fetch_pc  = pc;
            fetch_vld = 1'b1;
            fq.push_back(mdl_mem[idx]);
        end
        @(posedge clk); #1;
        fetch_vld = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int         L;
        for (int i = 0; i < int'(WORDS); i++) mdl_vld[i] = 1'b0;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; fetch_pc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_words_loaded", 32'(words_loaded), 32'd0);
        chk("rst_fetch_ir", fetch_ir, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Two-word image at full rate, good checksum
        img[0] = 32'h20010005;
        img[1] = 32'h20020007;
        stall_cnt = 0;
        do_load(1, 1'b1, 1'b0, 1'b0, -1);
        chk("full_rate_stalls", 32'(stall_cnt), 32'd0);
        do_fetch(32'd4);
        do_fetch(32'd0);

        // Same image, bad checksum
        do_load(1, 1'b0, 1'b0, 1'b0, -1);
        do_fetch(32'd4);

        // Oversized length rejected, memory untouched
        do_load(128, 1'b1, 1'b0, 1'b0, -1);
        do_fetch(32'd0);
        do_fetch(32'd4);

        // Throttled stream with stray start pulses
        for (int i = 0; i < 8; i++) img[i] = $urandom();
        do_load(7, 1'b1, 1'b1, 1'b1, -1);
        for (int i = 0; i < 8; i++) do_fetch(32'(i * 4));

        // Reset after five data bytes of a two-word load
        img[0] = $urandom();
        img[1] = $urandom();
        pulse_start();
        send_byte(8'd1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            b = (k < 4) ? img[0][(31 - 8*k) -: 8] : img[1][31:24];
            send_byte(b, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        end
        mdl_mem[0] = img[0];
        rx_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_rx_ready", 32'(rx_ready), 32'd0);
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_load_done", 32'(load_done), 32'd0);
        chk("midrst_load_err", 32'(load_err), 32'd0);
        chk("midrst_words_loaded", 32'(words_loaded), 32'd0);
        chk("midrst_fetch_ir", fetch_ir, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_fetch(32'd0);
        img[0] = $urandom();
        do_load(0, 1'b1, 1'b0, 1'b0, -1);
        do_fetch(32'd0);

        // Full memory: random fill, then pattern fill with a same-edge read of word 5
        for (int i = 0; i < int'(WORDS); i++) img[i] = $urandom();
        do_load(127, 1'b1, 1'b0, 1'b0, -1);
        for (int i = 0; i < int'(WORDS); i++) img[i] = 32'hA5000000 | 32'(i);
        do_load(127, 1'b1, 1'b0, 1'b0, 5);
        do_fetch(32'h000001FC);
        do_fetch(32'h00000200);
        for (int i = 0; i < 8; i++) do_fetch($urandom());

        // Random short loads
        for (int n = 0; n < 6; n++) begin
            L = int'($urandom_range(0, 20));
            for (int i = 0; i <= L; i++) img[i] = $urandom();
            do_load(L, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 1) == 1), -1);
            for (int i = 0; i < 4; i++) do_fetch($urandom());
        end

        repeat (3) @(posedge clk);
        #1;
        chk("load_queue_drained", 32'(lq.size()), 32'd0);
        chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
